sign_extend: RTL and testbench
==============================

// Module: sign_extend
// PURPOSE
//   Widens a DATA_2_WIDTH immediate to REG_DATA_WIDTH for the ALU operand mux
//   (alu_src) and branch/upper-immediate paths. Provides a zero-latency
//   combinational result (data_out) and a registered copy (data_q, valid_q)
//   for pipelined consumers.
//   Extension mode is selectable: sign, zero, sign-plus-shift, or upper-immediate.
// PARAMETERS
//   REG_DATA_WIDTH  16  output/register datapath width
//   DATA_2_WIDTH    4   immediate input width; legal range 1..REG_DATA_WIDTH
//   SHIFT_AMT       1   left shift applied in mode 2; legal range 0..REG_DATA_WIDTH-1
// PORTS
//   clk       in   1               rising-edge clock
//   rst_n     in   1               asynchronous active-low reset
//   data_in   in   DATA_2_WIDTH    immediate field
//   ext_mode  in   2               00 sign, 01 zero, 10 sign+shift, 11 upper
//   en        in   1               register load enable
//   in_valid  in   1               data_in qualifier, captured into valid_q
//   data_out  out  REG_DATA_WIDTH  combinational extended value
//   is_neg    out  1               data_out[REG_DATA_WIDTH-1], combinational
//   data_q    out  REG_DATA_WIDTH  registered data_out
//   valid_q   out  1               registered in_valid
// BEHAVIOUR
//   Interface: one clock (clk); reset rst_n is asynchronous and active-low.
//   Combinational path, no latency, independent of clk/rst_n/en:
//     mode 00: data_out = {replicate data_in[MSB], data_in}.
//     mode 01: data_out = {zeros, data_in}.
//     mode 10: sign-extend as mode 00, then << SHIFT_AMT.
//              Bits shifted past the MSB are discarded; zeros fill the LSBs.
//     mode 11: data_out = data_in << (REG_DATA_WIDTH-DATA_2_WIDTH).
//              The immediate occupies the MSBs; the low bits are zero.
//   DATA_2_WIDTH == REG_DATA_WIDTH:
//     modes 00/01 pass data_in through unchanged.
//     mode 11 also passes data_in through unchanged (shift of 0).
//   Outputs are never X for known inputs; no latches.
//   Registered path:
//     rst_n low asynchronously forces data_q=0 and valid_q=0.
//     The reset takes effect immediately, including mid-operation, and is held
//     while rst_n is low.
//     On rising clk with rst_n high and en=1: data_q <= data_out and
//     valid_q <= in_valid. Latency is 1 cycle.
//     With en=0: data_q and valid_q hold their values. in_valid is ignored.
//     data_q is loaded whenever en=1, whatever the value of in_valid.
//     The consumer qualifies data_q with valid_q.
//   Reset release: the first capture occurs on the first rising edge with
//   rst_n=1 and en=1.
// TESTING (REG_DATA_WIDTH=16, DATA_2_WIDTH=4, SHIFT_AMT=1)
//   1. Mode 00:
//      data_in=4'b0111 -> 0x0007, is_neg=0.
//      data_in=4'b1000 -> 0xFFF8, is_neg=1.
//      data_in=4'b1111 -> 0xFFFF, is_neg=1.
//      data_in=0 -> 0x0000.
//   2. Mode 01: 4'b1000 -> 0x0008; 4'b1111 -> 0x000F.
//   3. Mode 10: 4'b1110 -> 0xFFFC; 4'b0101 -> 0x000A.
//      Mode 11: 4'b1010 -> 0xA000.
//   4. Registered load, mode 00, en=1, in_valid=1, data_in=4'b1001:
//      after 1 edge, data_q=0xFFF9 and valid_q=1.
//      Then en=0 with new data_in: data_q and valid_q unchanged for 3 cycles.
//   5. Reset mid-operation: drop rst_n between edges -> data_q=0 and valid_q=0
//      immediately. Edges while rst_n=0 load nothing.
//   6. Exhaustive: all 16 data_in values x 4 modes, checked against a
//      reference model.
//      Repeat with DATA_2_WIDTH=16: modes 00, 01 and 11 must pass through.

Source files
------------

// File: rtl/sign_extend.sv
// sign_extend
// Widens an immediate field to the register datapath width for the ALU
// operand mux and the branch / upper-immediate paths. The extended value is
// available combinationally on data_out, with a registered copy (data_q)
// and its qualifier (valid_q) for pipelined consumers.
//
// ext_mode selects the extension:
//    00  sign extend
//    01  zero extend
//    10  sign extend, then shift left by SHIFT_AMT (LSBs zero-filled)
//    11  upper immediate: field placed in the MSBs, low bits zero
//
// DATA_2_WIDTH may equal REG_DATA_WIDTH. In that case there are no pad bits,
// so modes 00/01/11 pass the field through unchanged.

module sign_extend #(
   parameter int REG_DATA_WIDTH = 16,
   parameter int DATA_2_WIDTH   = 4,
   parameter int SHIFT_AMT      = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATA_2_WIDTH-1:0]   data_in,
   input  logic [1:0]                ext_mode,
   input  logic                      en,
   input  logic                      in_valid,
   output logic [REG_DATA_WIDTH-1:0] data_out,
   output logic                      is_neg,
   output logic [REG_DATA_WIDTH-1:0] data_q,
   output logic                      valid_q
);

   localparam int PAD_W = REG_DATA_WIDTH - DATA_2_WIDTH;

   localparam logic [1:0] MODE_SIGN  = 2'b00;
   localparam logic [1:0] MODE_ZERO  = 2'b01;
   localparam logic [1:0] MODE_SHIFT = 2'b10;
   localparam logic [1:0] MODE_UPPER = 2'b11;

   logic [REG_DATA_WIDTH-1:0] sext_val;
   logic [REG_DATA_WIDTH-1:0] zext_val;
   logic [REG_DATA_WIDTH-1:0] shift_val;
   logic [REG_DATA_WIDTH-1:0] upper_val;

   // A zero-width replication is illegal, so the full-width case is split out.
   generate
      if (PAD_W == 0) begin : g_full_width
         assign sext_val  = data_in;
         assign zext_val  = data_in;
         assign upper_val = data_in;
      end else begin : g_padded
         assign sext_val  = {{PAD_W{data_in[DATA_2_WIDTH-1]}}, data_in};
         assign zext_val  = {{PAD_W{1'b0}}, data_in};
         assign upper_val = {data_in, {PAD_W{1'b0}}};
      end
   endgenerate

   // Bits pushed past the MSB are simply dropped by the fixed-width result.
   assign shift_val = sext_val << SHIFT_AMT;

   // Select the extension; the default arm keeps data_out known for any mode.
   always_comb begin
      data_out = sext_val;
      case (ext_mode)
         MODE_SIGN:  data_out = sext_val;
         MODE_ZERO:  data_out = zext_val;
         MODE_SHIFT: data_out = shift_val;
         MODE_UPPER: data_out = upper_val;
         default:    data_out = sext_val;
      endcase
   end

   assign is_neg = data_out[REG_DATA_WIDTH-1];

   // Capture the extended value and its qualifier whenever en is high;
   // in_valid does not gate the data load, the consumer uses valid_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (en) begin
         data_q  <= data_out;
         valid_q <= in_valid;
      end
   end

endmodule

// File: tb/tb_sign_extend.sv
// Directed bench for sign_extend: combinational modes, registered load/hold,
// asynchronous reset, an exhaustive 4-bit sweep against a reference model,
// and a full-width (DATA_2_WIDTH == REG_DATA_WIDTH) instance.

module tb_sign_extend;

   logic        clk;
   logic        rst_n;
   logic [3:0]  data_in;
   logic [1:0]  ext_mode;
   logic        en;
   logic        in_valid;
   logic [15:0] data_out;
   logic        is_neg;
   logic [15:0] data_q;
   logic        valid_q;

   logic [15:0] w_data_in;
   logic [15:0] w_data_out;
   logic        w_is_neg;
   logic [15:0] w_data_q;
   logic        w_valid_q;

   int n_tests;
   int n_fail;

   sign_extend #(
      .REG_DATA_WIDTH (16),
      .DATA_2_WIDTH   (4),
      .SHIFT_AMT      (1)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .ext_mode (ext_mode),
      .en       (en),
      .in_valid (in_valid),
      .data_out (data_out),
      .is_neg   (is_neg),
      .data_q   (data_q),
      .valid_q  (valid_q)
   );

   sign_extend #(
      .REG_DATA_WIDTH (16),
      .DATA_2_WIDTH   (16),
      .SHIFT_AMT      (1)
   ) u_dut_wide (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (w_data_in),
      .ext_mode (ext_mode),
      .en       (en),
      .in_valid (in_valid),
      .data_out (w_data_out),
      .is_neg   (w_is_neg),
      .data_q   (w_data_q),
      .valid_q  (w_valid_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   // Reference model written arithmetically for the 4-bit instance.
   function automatic logic [15:0] ref_ext(input logic [3:0] d, input logic [1:0] m);
      int sv;
      int uv;
      uv = int'(d);
      sv = (uv >= 8) ? uv - 16 : uv;
      case (m)
         2'b00:   return 16'(sv & 32'hFFFF);
         2'b01:   return 16'(uv);
         2'b10:   return 16'((sv * 2) & 32'hFFFF);
         default: return 16'((uv * 4096) & 32'hFFFF);
      endcase
   endfunction

   task automatic comb_vec(input string tag, input logic [1:0] m, input logic [3:0] d,
                           input logic [15:0] exp);
      ext_mode = m;
      data_in  = d;
      #1;
      check(tag, data_out, exp);
   endtask

   logic [15:0] wide_vals [4];

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      en        = 1'b0;
      in_valid  = 1'b0;
      ext_mode  = 2'b00;
      data_in   = 4'h0;
      w_data_in = 16'h0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_data_q", data_q, 16'h0000);
      check("reset_valid_q", {15'b0, valid_q}, 16'h0000);

      @(negedge clk);
      rst_n = 1'b1;

      // mode 00
      comb_vec("m00_0111", 2'b00, 4'b0111, 16'h0007);
      check("m00_0111_neg", {15'b0, is_neg}, 16'h0000);
      comb_vec("m00_1000", 2'b00, 4'b1000, 16'hFFF8);
      check("m00_1000_neg", {15'b0, is_neg}, 16'h0001);
      comb_vec("m00_1111", 2'b00, 4'b1111, 16'hFFFF);
      check("m00_1111_neg", {15'b0, is_neg}, 16'h0001);
      comb_vec("m00_0000", 2'b00, 4'b0000, 16'h0000);
      // mode 01
      comb_vec("m01_1000", 2'b01, 4'b1000, 16'h0008);
      comb_vec("m01_1111", 2'b01, 4'b1111, 16'h000F);
      check("m01_1111_neg", {15'b0, is_neg}, 16'h0000);
      // mode 10 / 11
      comb_vec("m10_1110", 2'b10, 4'b1110, 16'hFFFC);
      comb_vec("m10_0101", 2'b10, 4'b0101, 16'h000A);
      comb_vec("m11_1010", 2'b11, 4'b1010, 16'hA000);
      check("m11_1010_neg", {15'b0, is_neg}, 16'h0001);

      // registered load
      @(negedge clk);
      ext_mode = 2'b00;
      data_in  = 4'b1001;
      en       = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("load_data_q", data_q, 16'hFFF9);
      check("load_valid_q", {15'b0, valid_q}, 16'h0001);

      // hold with en low
      @(negedge clk);
      en       = 1'b0;
      in_valid = 1'b0;
      data_in  = 4'b0011;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold_data_q_%0d", i), data_q, 16'hFFF9);
         check($sformatf("hold_valid_q_%0d", i), {15'b0, valid_q}, 16'h0001);
      end

      // en=1, in_valid=0 still loads data
      @(negedge clk);
      en       = 1'b1;
      in_valid = 1'b0;
      data_in  = 4'b1000;
      @(posedge clk);
      #1;
      check("noval_data_q", data_q, 16'hFFF8);
      check("noval_valid_q", {15'b0, valid_q}, 16'h0000);

      // load again then reset mid-cycle
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = 4'b0110;
      @(posedge clk);
      #1;
      check("pre_rst_data_q", data_q, 16'h0006);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_data_q", data_q, 16'h0000);
      check("async_rst_valid_q", {15'b0, valid_q}, 16'h0000);
      check("async_rst_wide_q", w_data_q, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      check("held_rst_data_q", data_q, 16'h0000);
      check("held_rst_valid_q", {15'b0, valid_q}, 16'h0000);

      // first capture after release
      @(negedge clk);
      rst_n    = 1'b1;
      data_in  = 4'b0111;
      ext_mode = 2'b11;
      @(posedge clk);
      #1;
      check("post_rst_data_q", data_q, 16'h7000);
      check("post_rst_valid_q", {15'b0, valid_q}, 16'h0001);

      // exhaustive 4-bit sweep
      @(negedge clk);
      en = 1'b0;
      for (int m = 0; m < 4; m++) begin
         for (int d = 0; d < 16; d++) begin
            ext_mode = 2'(m);
            data_in  = 4'(d);
            #1;
            check($sformatf("sweep_m%0d_d%0d", m, d), data_out, ref_ext(4'(d), 2'(m)));
            check($sformatf("sweep_neg_m%0d_d%0d", m, d), {15'b0, is_neg},
                  {15'b0, ref_ext(4'(d), 2'(m)) >> 15});
         end
      end

      // full-width instance
      wide_vals[0] = 16'h8001;
      wide_vals[1] = 16'h1234;
      wide_vals[2] = 16'hFFFF;
      wide_vals[3] = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         w_data_in = wide_vals[i];
         ext_mode  = 2'b00;
         #1;
         check($sformatf("wide_m00_%0d", i), w_data_out, wide_vals[i]);
         ext_mode = 2'b01;
         #1;
         check($sformatf("wide_m01_%0d", i), w_data_out, wide_vals[i]);
         ext_mode = 2'b11;
         #1;
         check($sformatf("wide_m11_%0d", i), w_data_out, wide_vals[i]);
      end
      w_data_in = 16'hC003;
      ext_mode  = 2'b10;
      #1;
      check("wide_m10_c003", w_data_out, 16'h8006);
      check("wide_m10_neg", {15'b0, w_is_neg}, 16'h0001);

      // wide registered path
      @(negedge clk);
      en        = 1'b1;
      in_valid  = 1'b1;
      ext_mode  = 2'b01;
      w_data_in = 16'hBEEF;
      @(posedge clk);
      #1;
      check("wide_load_q", w_data_q, 16'hBEEF);
      check("wide_load_valid", {15'b0, w_valid_q}, 16'h0001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
